// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin A2D conversion scheduler driving a shared SPI master
module a2d_sched #(
    parameter int GAP_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        cnv_cmplt
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT1,
        GAP,
        READ,
        WAIT2
    } state_t;

    // Last value of the GAP counter before moving on to the read transaction.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [2:0]  ch;
    logic [3:0]  gap_cnt;
    logic        gap_clr;
    logic        gap_inc;
    logic        load;
    logic        rd_unused;

    // Only the low 12 bits of the receive word carry the conversion result.
    assign rd_unused = &{1'b0, rd_data[15:12]};

    // Round-robin pointer to physical A2D channel number.
    always_comb begin
        ch = 3'd0;
        case (ptr)
            2'd0: ch = 3'd0;
            2'd1: ch = 3'd4;
            2'd2: ch = 3'd5;
            2'd3: ch = 3'd6;
            default: ch = 3'd0;
        endcase
    end

    // Next-state and strobe decode; done is only honoured in the two wait states.
    always_comb begin
        state_nxt = state;
        wrt       = 1'b0;
        load      = 1'b0;
        gap_clr   = 1'b0;
        gap_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (nxt) state_nxt = ADDR;
            end
            ADDR: begin
                wrt       = 1'b1;
                state_nxt = WAIT1;
            end
            WAIT1: begin
                if (done) begin
                    gap_clr   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = READ;
                else                     gap_inc   = 1'b1;
            end
            READ: begin
                wrt       = 1'b1;
                state_nxt = WAIT2;
            end
            WAIT2: begin
                if (done) begin
                    load      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // GAP idle-cycle counter, cleared as the address transaction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       gap_cnt <= 4'd0;
        else if (gap_clr) gap_cnt <= 4'd0;
        else if (gap_inc) gap_cnt <= gap_cnt + 4'd1;
    end

    // Command word is captured when a conversion starts and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cmd <= 16'h0000;
        else if (state == IDLE && nxt) cmd <= {2'b00, ch, 11'h000};
    end

    // Pointer advance and completion pulse, both one cycle after the read finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 2'd0;
            cnv_cmplt <= 1'b0;
        end else begin
            cnv_cmplt <= load;
            if (load) ptr <= ptr + 2'd1;
        end
    end

    // Result registers; only the one selected by the pointer is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else if (load) begin
            case (ptr)
                2'd0: lft_ld    <= rd_data[11:0];
                2'd1: rght_ld   <= rd_data[11:0];
                2'd2: steer_pot <= rd_data[11:0];
                2'd3: batt      <= rd_data[11:0];
                default: ;
            endcase
        end
    end

endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 SHALL have parameter GAP_CYC, default 1, giving the idle cycles between the address transaction and the read transaction (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-004 SHALL have port nxt, input, 1, request to run one conversion on the current channel; sampled only in IDLE.
REQ-005 SHALL have port wrt, output, 1, one-cycle strobe that starts an SPI transaction on the shared SPI master.
REQ-006 SHALL have port cmd, output, 16, SPI word: {2'b00, ch[2:0], 11'h000}.
REQ-007 SHALL have port done, input, 1, one-cycle pulse from the SPI master at the end of a transaction.
REQ-008 SHALL have port rd_data, input, 16, SPI receive word, valid in the cycle done is high.
REQ-009 SHALL have ports lft_ld, rght_ld, steer_pot and batt, each output, 12, holding the latest conversion result per channel.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port cnv_cmplt, output, 1, one-cycle pulse when a result register is updated.

Function
REQ-012 SHALL implement the states IDLE, ADDR, WAIT1, GAP, READ and WAIT2.
REQ-013 SHALL use a 2-bit round-robin pointer: 0 = lft_ld (ch 0), 1 = rght_ld (ch 4), 2 = steer_pot (ch 5), 3 = batt (ch 6).
REQ-014 SHALL go from IDLE to ADDR when nxt=1, and SHALL stay in IDLE otherwise.
REQ-015 SHALL, in ADDR, assert wrt for exactly one cycle with cmd for the pointer channel, then go to WAIT1.
REQ-016 SHALL, in WAIT1, hold until done=1 and then go to GAP; rd_data SHALL be ignored for this transaction.
REQ-017 SHALL stay in GAP for exactly GAP_CYC cycles, counted by an internal counter cleared on GAP entry, then go to READ.
REQ-018 SHALL, in READ, assert wrt for one cycle with the same cmd, then go to WAIT2.
REQ-019 SHALL, in WAIT2 with done=1, load rd_data[11:0] into the pointer's result register, advance the pointer (3 wraps to 0), pulse cnv_cmplt in the next cycle, and go to IDLE.
REQ-020 SHALL hold cmd stable from ADDR through WAIT2, and SHALL keep cmd unchanged in IDLE.
REQ-021 SHALL give latency from nxt to the first wrt of exactly 1 cycle.
REQ-022 SHALL give latency from the WAIT2 done to cnv_cmplt of exactly 1 cycle, with the result register valid in the same cycle as cnv_cmplt.
REQ-023 SHALL ignore nxt whenever the state is not IDLE, with no queuing.
REQ-024 SHALL ignore done in IDLE, ADDR, GAP and READ.
REQ-025 SHALL start a new conversion immediately if nxt=1 in the cycle cnv_cmplt is high (state is IDLE), so back-to-back rounds are legal.
REQ-026 SHALL keep wrt low except for exactly two cycles per conversion.
REQ-027 SHALL not change any result register other than the one selected by the pointer.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-transaction, immediately force the state to IDLE, the pointer to 0, the GAP counter to 0, wrt=0, cnv_cmplt=0, busy=0, cmd=16'h0000, and all four result registers to 12'h000.
REQ-029 SHALL, after rst_n deasserts, do nothing until nxt is sampled high; a done pulse still pending from an aborted transaction SHALL be ignored.

Verification
REQ-030 SHALL be verified for a single conversion: after reset, pulse nxt, model answers each wrt with done 40 cycles later and rd_data=16'h0ABC -> cmd=16'h0000 on both wrt, lft_ld=12'hABC, cnv_cmplt one cycle after the second done, busy low afterward.
REQ-031 SHALL be verified for a full round-robin: 5 nxt requests with rd_data 12'h111, 12'h222, 12'h333, 12'h444, 12'h555 -> cmd sequence 16'h0000, 16'h2000, 16'h2800, 16'h3000, 16'h0000; final lft_ld=12'h555, rght_ld=12'h222, steer_pot=12'h333, batt=12'h444.
REQ-032 SHALL be verified for the GAP count: with GAP_CYC=3, the second wrt occurs exactly 4 cycles after the first done.
REQ-033 SHALL be verified for ignored inputs: nxt held high for the whole conversion plus stray done pulses in GAP -> exactly two wrt strobes per conversion, and one new conversion starts in the cycle after cnv_cmplt.
REQ-034 SHALL be verified for reset mid-operation: assert rst_n=0 in WAIT2 with rght_ld previously 12'h7FF -> all outputs 0 within the same cycle, and after release the next conversion targets channel 0 (cmd=16'h0000).
